// File: rtl/clk_en_gen.sv
// Multi-channel phase-accumulator clock-enable generator with a PLL-style lock sequencer.
// Optional per-channel square-wave outputs are enabled by defining CLK_EN_GEN_TOGGLE_EN.
module clk_en_gen #(
  parameter int                CHANNELS    = 4,
  parameter int                ACC_W       = 32,
  parameter logic [ACC_W-1:0]  DEFAULT_INC = ACC_W'(32'h3333_3334),
  parameter int                LOCK_CYCLES = 16,
  localparam int               CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [ACC_W-1:0]    wr_inc,
  input  logic                sync,
  output logic [CHANNELS-1:0] ce,
  output logic                locked
`ifdef CLK_EN_GEN_TOGGLE_EN
  ,output logic [CHANNELS-1:0] clk_tgl
`endif
);

  // state       | meaning
  // ST_UNLOCKED | counting quiet cycles, strobes withheld
  // ST_LOCKED   | rates settled, strobes emitted
  typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_t;

  state_t              state_q, state_d;
  logic [15:0]         qcnt_q, qcnt_d;
  logic                locked_q, locked_d;
  logic [CHANNELS-1:0] ce_q, ce_d;
  logic [ACC_W-1:0]    inc_q [CHANNELS];
  logic [ACC_W-1:0]    inc_d [CHANNELS];
  logic [ACC_W-1:0]    acc_q [CHANNELS];
  logic [ACC_W-1:0]    acc_d [CHANNELS];
  logic                wr_ok;
  logic                evt;
  logic                locked_nx;
  logic [ACC_W:0]      sum;

  // Writes to channels that do not exist are dropped before they can disturb lock.
  assign wr_ok = wr_en && (int'(wr_ch) < CHANNELS);
  assign evt   = wr_ok || sync;

  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    if (evt) begin
      state_d = ST_UNLOCKED;
      qcnt_d  = '0;
    end else if (state_q == ST_UNLOCKED) begin
      if (qcnt_q == 16'(LOCK_CYCLES - 1)) state_d = ST_LOCKED;
      else                                qcnt_d  = qcnt_q + 16'd1;
    end
    locked_nx = (state_d == ST_LOCKED);
    locked_d  = locked_nx;
  end

  always_comb begin
    sum  = '0;
    ce_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sum      = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
      acc_d[i] = sum[ACC_W-1:0];
      inc_d[i] = inc_q[i];
      if (wr_ok && (wr_ch == CH_W'(i))) begin
        inc_d[i] = wr_inc;
        acc_d[i] = '0;
      end
      if (sync) acc_d[i] = '0;
      // Accumulators keep running while unlocked; only the strobe is gated.
      ce_d[i] = sum[ACC_W] && locked_nx && !sync;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_UNLOCKED;
      qcnt_q   <= '0;
      locked_q <= 1'b0;
      ce_q     <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        inc_q[i] <= DEFAULT_INC;
        acc_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      qcnt_q   <= qcnt_d;
      locked_q <= locked_d;
      ce_q     <= ce_d;
      for (int i = 0; i < CHANNELS; i++) begin
        inc_q[i] <= inc_d[i];
        acc_q[i] <= acc_d[i];
      end
    end
  end

  assign ce     = ce_q;
  assign locked = locked_q;

`ifdef CLK_EN_GEN_TOGGLE_EN
  logic [CHANNELS-1:0] tgl_q, tgl_d;

  always_comb begin
    tgl_d = sync ? '0 : (tgl_q ^ ce_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) tgl_q <= '0;
    else        tgl_q <= tgl_d;
  end

  assign clk_tgl = tgl_q;
`endif

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen: lock timing, rate changes, ignored writes, sync and mid-stream reset.
// Also checks clk_tgl when built with CLK_EN_GEN_TOGGLE_EN.
module tb_clk_en_gen;

  localparam int LOCK = 16;

  logic        clk = 1'b0;
  logic        rst_n, wr_en, sync;
  logic [1:0]  wr_ch;
  logic [31:0] wr_inc;
  logic [3:0]  ce;
  logic        locked;

  logic        wr_en5, sync5;
  logic [2:0]  wr_ch5;
  logic [31:0] wr_inc5;
  logic [4:0]  ce5;
  logic        locked5;

`ifdef CLK_EN_GEN_TOGGLE_EN
  logic [3:0]  clk_tgl;
  logic [4:0]  clk_tgl5;
  logic [3:0]  tgl_exp;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_evt, last_rst, tgl_clr_at;
  int per  [4];
  int base [4];

  always #5 clk = ~clk;

  clk_en_gen #(.CHANNELS(4), .ACC_W(32), .LOCK_CYCLES(LOCK)) u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_inc(wr_inc),
    .sync(sync), .ce(ce), .locked(locked)
`ifdef CLK_EN_GEN_TOGGLE_EN
    , .clk_tgl(clk_tgl)
`endif
  );

  // Five channels so that an out-of-range channel number is representable on wr_ch.
  clk_en_gen #(.CHANNELS(5), .ACC_W(32), .LOCK_CYCLES(LOCK)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en5), .wr_ch(wr_ch5), .wr_inc(wr_inc5),
    .sync(sync5), .ce(ce5), .locked(locked5)
`ifdef CLK_EN_GEN_TOGGLE_EN
    , .clk_tgl(clk_tgl5)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    logic [3:0] ce_exp;
    logic [4:0] ce5_exp;
    logic       lk, lk5;
    @(posedge clk);
    cyc++;
    #1;
    lk = (cyc - last_evt) >= LOCK;
    for (int i = 0; i < 4; i++)
      ce_exp[i] = lk && (per[i] != 0) && (cyc > base[i]) && (((cyc - base[i]) % per[i]) == 0);
    chk("locked", {63'd0, locked}, {63'd0, lk});
    chk("ce", {60'd0, ce}, {60'd0, ce_exp});
    lk5 = (cyc - last_rst) >= LOCK;
    ce5_exp = (lk5 && ((cyc - last_rst) % 5 == 0)) ? 5'h1F : 5'h00;
    chk("locked5", {63'd0, locked5}, {63'd0, lk5});
    chk("ce5", {59'd0, ce5}, {59'd0, ce5_exp});
`ifdef CLK_EN_GEN_TOGGLE_EN
    if (cyc == tgl_clr_at) tgl_exp = '0;
    else                   tgl_exp = tgl_exp ^ ce_exp;
    chk("clk_tgl", {60'd0, clk_tgl}, {60'd0, tgl_exp});
`endif
  endtask

  task automatic run_to(input int e);
    while (cyc < e) step();
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_inc = '0; sync = 1'b0;
    wr_en5 = 1'b0; wr_ch5 = '0; wr_inc5 = '0; sync5 = 1'b0;
    tgl_clr_at = -1;
    repeat (3) @(posedge clk);
    cyc = 0; last_evt = 0; last_rst = 0;
    for (int i = 0; i < 4; i++) begin per[i] = 5; base[i] = 0; end
`ifdef CLK_EN_GEN_TOGGLE_EN
    tgl_exp = '0;
`endif
    #1;
    chk("rst_locked", {63'd0, locked}, 64'd0);
    chk("rst_ce", {60'd0, ce}, 64'd0);
    chk("rst_locked5", {63'd0, locked5}, 64'd0);
    chk("rst_ce5", {59'd0, ce5}, 64'd0);
`ifdef CLK_EN_GEN_TOGGLE_EN
    chk("rst_clk_tgl", {60'd0, clk_tgl}, 64'd0);
`endif
    rst_n = 1'b1;

    // Lock after reset; ignored write to channel 5 on the five-channel instance.
    run_to(24);
    wr_en5 = 1'b1; wr_ch5 = 3'd5; wr_inc5 = 32'd1;
    step();
    wr_en5 = 1'b0;
    run_to(35);

    // ch1 to half rate
    wr_en = 1'b1; wr_ch = 2'd1; wr_inc = 32'h8000_0000;
    last_evt = cyc + 1; base[1] = cyc + 1; per[1] = 2;
    step();
    wr_en = 1'b0;
    run_to(71);

    // ch2 stopped
    wr_en = 1'b1; wr_ch = 2'd2; wr_inc = 32'h0;
    last_evt = cyc + 1; base[2] = cyc + 1; per[2] = 0;
    step();
    wr_en = 1'b0;
    run_to(95);

    // ch3 to period 8
    wr_en = 1'b1; wr_ch = 2'd3; wr_inc = 32'h2000_0000;
    last_evt = cyc + 1; base[3] = cyc + 1; per[3] = 8;
    step();
    wr_en = 1'b0;
    run_to(130);

    // sync: all phases restart together
    sync = 1'b1;
    last_evt = cyc + 1; tgl_clr_at = cyc + 1;
    for (int i = 0; i < 4; i++) base[i] = cyc + 1;
    step();
    sync = 1'b0;
    run_to(220);

    // one-cycle reset with sync and a write also asserted
    rst_n = 1'b0; sync = 1'b1; wr_en = 1'b1; wr_ch = 2'd0; wr_inc = 32'd1;
    last_evt = cyc + 1; last_rst = cyc + 1; tgl_clr_at = cyc + 1;
    for (int i = 0; i < 4; i++) begin per[i] = 5; base[i] = cyc + 1; end
    step();
    rst_n = 1'b1; sync = 1'b0; wr_en = 1'b0;
    run_to(262);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
